// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier command sequencer.
// The op struct documents the FIFO entry layout {a, b, tag} at the default widths.
package mult_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TAG_W_DEF   = 4;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [TAG_W_DEF-1:0]  tag;
  } op_t;

  function automatic int unsigned op_width(input int unsigned data_w, input int unsigned tag_w);
    return 2 * data_w + tag_w;
  endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO with full/empty flags and synchronous active-low reset.
// Pointers carry one wrap bit so full and empty are distinguishable without a counter.
module mult_op_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/mult_op_sequencer.sv
// Command stage for the pipelined multiplier: buffers operand pairs, issues one op at a
// time with a start pulse, waits for done (or times out) and returns product and tag.
module mult_op_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_a,
  input  logic [DATA_W-1:0]   s_b,
  input  logic [TAG_W-1:0]    s_tag,
  output logic [DATA_W-1:0]   mult_a,
  output logic [DATA_W-1:0]   mult_b,
  output logic                mult_start,
  input  logic                mult_done,
  input  logic [2*DATA_W-1:0] mult_result,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*DATA_W-1:0] m_result,
  output logic [TAG_W-1:0]    m_tag,
  output logic                m_error,
  output logic                busy
);

  localparam int unsigned OP_W  = op_width(DATA_W, TAG_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mult_a;
  logic [DATA_W-1:0]   r_mult_b;
  logic [TAG_W-1:0]    r_tag;
  logic                r_mult_start;
  logic                r_m_valid;
  logic [2*DATA_W-1:0] r_m_result;
  logic [TAG_W-1:0]    r_m_tag;
  logic                r_m_error;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [OP_W-1:0]     w_head;

  assign w_push = s_valid && s_ready;
  // The head is popped on the IDLE->ISSUE edge so the start pulse and operands are
  // already registered for the single ISSUE cycle.
  assign w_pop  = (r_state == StIdle) && !w_empty;

  mult_op_fifo #(
    .WIDTH (OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({s_a, s_b, s_tag}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_tag        <= '0;
      r_mult_start <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_result   <= '0;
      r_m_tag      <= '0;
      r_m_error    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            {r_mult_a, r_mult_b, r_tag} <= w_head;
            r_mult_start                <= 1'b1;
            r_state                     <= StIssue;
          end
        end
        StIssue: begin
          r_mult_start <= 1'b0;
          r_cnt        <= '0;
          r_state      <= StWait;
        end
        StWait: begin
          if (mult_done) begin
            r_m_result <= mult_result;
            r_m_tag    <= r_tag;
            r_m_error  <= 1'b0;
            r_m_valid  <= 1'b1;
            r_state    <= StResp;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_m_result <= '0;
            r_m_tag    <= r_tag;
            r_m_error  <= 1'b1;
            r_m_valid  <= 1'b1;
            r_state    <= StResp;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StResp: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_ready    = !w_full;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;
  assign mult_start = r_mult_start;
  assign m_valid    = r_m_valid;
  assign m_result   = r_m_result;
  assign m_tag      = r_m_tag;
  assign m_error    = r_m_error;
  assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Directed bench for mult_op_sequencer: a 3-stage multiplier model (done 4 cycles after
// start) plus a stub path that forces mult_done for timeout and stale-done cases.
module tb_mult_op_sequencer;
  import mult_seq_pkg::*;

  localparam int unsigned DW      = 8;
  localparam int unsigned TW      = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;
  logic [TW-1:0] s_tag = '0;
  logic [DW-1:0] mult_a;
  logic [DW-1:0] mult_b;
  logic          mult_start;
  logic          mult_done;
  logic [15:0]   mult_result;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [15:0]   m_result;
  logic [TW-1:0] m_tag;
  logic          m_error;
  logic          busy;

  logic          stub = 1'b0;
  logic          inj_done = 1'b0;
  logic [15:0]   inj_res = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    op_t         op;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic [15:0]   res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   cyc = 0;

  always #5 clk = ~clk;

  mult_op_sequencer #(
    .DATA_W  (DW),
    .TAG_W   (TW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_a         (s_a),
    .s_b         (s_b),
    .s_tag       (s_tag),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_start  (mult_start),
    .mult_done   (mult_done),
    .mult_result (mult_result),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_result    (m_result),
    .m_tag       (m_tag),
    .m_error     (m_error),
    .busy        (busy)
  );

  // Multiplier model: start seen at edge C -> done/result visible after edge C+3.
  logic [2:0]  mdl_v = '0;
  logic [15:0] mdl_p0 = '0, mdl_p1 = '0, mdl_p2 = '0, mdl_res = '0;
  logic        mdl_done = 1'b0;

  always @(posedge clk) begin
    mdl_v    <= {mdl_v[1:0], mult_start};
    mdl_p0   <= 16'(mult_a) * 16'(mult_b);
    mdl_p1   <= mdl_p0;
    mdl_p2   <= mdl_p1;
    mdl_done <= mdl_v[2];
    mdl_res  <= mdl_p2;
  end

  assign mult_done   = stub ? inj_done : mdl_done;
  assign mult_result = stub ? inj_res : mdl_res;

  always @(posedge clk) begin
    cyc++;
    if (mult_start) starts.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tag);
    int   w = 0;
    exp_t e;
    e.res = 16'(a) * 16'(b);
    e.tag = tag;
    exp_q.push_back(e);
    s_a = a; s_b = b; s_tag = tag; s_valid = 1'b1;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) check("push_stall", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic collect(input int n, input string name);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      int w = 0;
      while (!m_valid && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!m_valid) begin
        check({name, "_timeout"}, {31'd0, m_valid}, 32'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        check({name, "_extra"}, 32'(exp_q.size()), 32'd1);
        return;
      end
      e = exp_q.pop_front();
      check({name, "_result"}, 32'(m_result), 32'(e.res));
      check({name, "_tag"}, 32'(m_tag), 32'(e.tag));
      check({name, "_error"}, {31'd0, m_error}, 32'd0);
      @(negedge clk);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int lat;
    int n0;
    int cnt;
    logic stable;
    logic seen;
    logic [15:0] h_res;
    logic [TW-1:0] h_tag;
    logic h_err;

    vecs[0] = '{op: '{a: 8'd3,   b: 8'd5,   tag: 4'd2},  res: 16'd15};
    vecs[1] = '{op: '{a: 8'd255, b: 8'd255, tag: 4'd7},  res: 16'd65025};
    vecs[2] = '{op: '{a: 8'd0,   b: 8'd200, tag: 4'd1},  res: 16'd0};
    vecs[3] = '{op: '{a: 8'd12,  b: 8'd11,  tag: 4'd9},  res: 16'd132};
    vecs[4] = '{op: '{a: 8'd200, b: 8'd3,   tag: 4'd15}, res: 16'd600};
    vecs[5] = '{op: '{a: 8'd128, b: 8'd2,   tag: 4'd0},  res: 16'd256};

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_outs", {m_result, mult_a, mult_b}, 32'd0);
    check("rst_flags", {28'd0, m_tag} | {31'd0, m_error} | {31'd0, mult_start}, 32'd0);

    // Single ops from an idle pipeline: latency, product, tag, one start each
    foreach (vecs[i]) begin
      n0 = starts.size();
      s_a = vecs[i].op.a; s_b = vecs[i].op.b; s_tag = vecs[i].op.tag; s_valid = 1'b1;
      check($sformatf("v%0d_ready", i), {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      lat = 1;
      while (!m_valid && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd7);
      check($sformatf("v%0d_result", i), 32'(m_result), 32'(vecs[i].res));
      check($sformatf("v%0d_tag", i), 32'(m_tag), 32'(vecs[i].op.tag));
      check($sformatf("v%0d_error", i), {31'd0, m_error}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done", i), {30'd0, m_valid, busy}, 32'd0);
      check($sformatf("v%0d_starts", i), 32'(starts.size() - n0), 32'd1);
      check($sformatf("v%0d_hold_a", i), {16'd0, mult_a, mult_b},
            {16'd0, vecs[i].op.a, vecs[i].op.b});
    end

    // Back-to-back burst of 5 with m_ready=1
    repeat (2) @(negedge clk);
    starts.delete();
    exp_q.delete();
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) push_op(8'(10 + i), 8'(3 * i + 1), 4'(i + 4));
        check("burst_full", {31'd0, s_ready}, 32'd0);
      end
      collect(5, "burst");
    join
    check("burst_nstarts", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("burst_spacing%0d", i), 32'(starts[i] - starts[i-1]), 32'd7);

    // Backpressure: hold m_ready=0 for 20 cycles in RESP
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(8'(20 + i), 8'(7 + i), 4'(10 - i));
    check("bp_full", {31'd0, s_ready}, 32'd0);
    cnt = 0;
    while (!m_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    h_res = m_result; h_tag = m_tag; h_err = m_error;
    n0 = starts.size();
    stable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_valid || m_result !== h_res || m_tag !== h_tag || m_error !== h_err) stable = 1'b0;
      if (s_ready) seen = 1'b1;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_s_ready_low", {31'd0, seen}, 32'd0);
    check("bp_no_start", 32'(starts.size() - n0), 32'd0);
    m_ready = 1'b1;
    collect(5, "bp");

    // Timeout through the stub, then a stale done injected in IDLE
    repeat (2) @(negedge clk);
    stub = 1'b1;
    n0 = starts.size();
    s_a = 8'd9; s_b = 8'd9; s_tag = 4'd3; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check("to_latency", 32'(lat), 32'(3 + TIMEOUT));
    check("to_error", {31'd0, m_error}, 32'd1);
    check("to_result", 32'(m_result), 32'd0);
    check("to_tag", 32'(m_tag), 32'd3);
    check("to_starts", 32'(starts.size() - n0), 32'd1);
    repeat (3) @(negedge clk);
    inj_res = 16'h1234;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("stale_no_valid", {31'd0, seen}, 32'd0);
    check("stale_result", 32'(m_result), 32'd0);
    check("stale_error", {31'd0, m_error}, 32'd1);
    check("stale_busy", {31'd0, busy}, 32'd0);
    stub = 1'b0;
    inj_res = '0;

    // Reset during WAIT with 3 ops still queued
    repeat (6) @(negedge clk);
    exp_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_op(8'(50 + i), 8'd2, 4'(i + 1));
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mrst_outs", {m_result, mult_a, mult_b}, 32'd0);
    check("mrst_flags", {28'd0, m_tag} | {31'd0, m_error} | {31'd0, mult_start}, 32'd0);
    check("mrst_s_ready", {31'd0, s_ready}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    n0 = starts.size();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid || busy) seen = 1'b1;
    end
    check("mrst_quiet", {31'd0, seen}, 32'd0);
    check("mrst_no_start", 32'(starts.size() - n0), 32'd0);
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
